// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-ready handshake and retired-instruction counter.
// Define MC_BNE_EN to decode bne (opcode 000101) through the BRANCH state.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk_w,
  input  logic             i_rst_w,
  input  logic [5:0]       i_op_w,
  input  logic [5:0]       i_funct_w,
  input  logic             i_zero_w,
  input  logic             i_mem_ready_w,
  output logic             o_iord_w,
  output logic             o_mem_write_w,
  output logic             o_ir_write_w,
  output logic             o_pc_en_w,
  output logic             o_reg_write_w,
  output logic             o_reg_dst_w,
  output logic             o_mem_to_reg_w,
  output logic             o_alu_src_a_w,
  output logic [1:0]       o_alu_src_b_w,
  output logic [1:0]       o_pc_src_w,
  output logic [2:0]       o_alu_control_w,
  output logic             o_illegal_w,
  output logic [3:0]       o_state_w,
  output logic [CNT_W-1:0] o_instr_count_w
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // Raw enables before reset gating.
  logic mem_write, ir_write, pc_en, reg_write, illegal;

  logic op_legal;
  logic branch_take;

  always_comb begin
    op_legal = 1'b0;
    case (i_op_w)
      OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: op_legal = 1'b1;
`ifdef MC_BNE_EN
      OpBne:                                   op_legal = 1'b1;
`endif
      default:                                 op_legal = 1'b0;
    endcase
  end

`ifdef MC_BNE_EN
  // Remembers whether the branch in flight is bne so BRANCH can invert the zero test.
  logic is_bne_q, is_bne_d;

  always_comb begin
    is_bne_d = is_bne_q;
    if (state_q == StDecode) is_bne_d = (i_op_w == OpBne);
  end

  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) is_bne_q <= 1'b0;
    else          is_bne_q <= is_bne_d;
  end

  assign branch_take = is_bne_q ? ~i_zero_w : i_zero_w;
`else
  assign branch_take = i_zero_w;
`endif

  // State and counter registers
  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch:  if (i_mem_ready_w) state_d = StDecode;
      StDecode: begin
        case (i_op_w)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
`ifdef MC_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (i_op_w == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (i_mem_ready_w) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (i_mem_ready_w) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec:   state_d = StAluWb;
      StAluWb, StBranch, StAddiWb, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // Output decode
  always_comb begin
    o_iord_w        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    pc_en           = 1'b0;
    reg_write       = 1'b0;
    o_reg_dst_w     = 1'b0;
    o_mem_to_reg_w  = 1'b0;
    o_alu_src_a_w   = 1'b0;
    o_alu_src_b_w   = 2'b00;
    o_pc_src_w      = 2'b00;
    o_alu_control_w = AluAdd;
    illegal         = 1'b0;
    unique case (state_q)
      StFetch: begin
        o_alu_src_b_w = 2'b01;
        ir_write      = i_mem_ready_w;
        pc_en         = i_mem_ready_w;
      end
      StDecode: begin
        o_alu_src_b_w = 2'b11;
        illegal       = ~op_legal;
      end
      StMemAdr: begin
        o_alu_src_a_w = 1'b1;
        o_alu_src_b_w = 2'b10;
      end
      StMemRd: o_iord_w = 1'b1;
      StMemWb: begin
        o_mem_to_reg_w = 1'b1;
        reg_write      = 1'b1;
      end
      StMemWr: begin
        o_iord_w  = 1'b1;
        mem_write = 1'b1;
      end
      StExec: begin
        o_alu_src_a_w = 1'b1;
        case (i_funct_w)
          6'b100000: o_alu_control_w = AluAdd;
          6'b100010: o_alu_control_w = AluSub;
          6'b100100: o_alu_control_w = AluAnd;
          6'b100101: o_alu_control_w = AluOr;
          6'b101010: o_alu_control_w = AluSlt;
          default:   illegal         = 1'b1;
        endcase
      end
      StAluWb: begin
        o_reg_dst_w = 1'b1;
        reg_write   = 1'b1;
      end
      StBranch: begin
        o_alu_src_a_w   = 1'b1;
        o_alu_control_w = AluSub;
        o_pc_src_w      = 2'b01;
        pc_en           = branch_take;
      end
      StAddiEx: begin
        o_alu_src_a_w = 1'b1;
        o_alu_src_b_w = 2'b10;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        o_pc_src_w = 2'b10;
        pc_en      = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables and the illegal pulse are suppressed as soon as reset asserts.
  assign o_mem_write_w   = mem_write & i_rst_w;
  assign o_ir_write_w    = ir_write  & i_rst_w;
  assign o_pc_en_w       = pc_en     & i_rst_w;
  assign o_reg_write_w   = reg_write & i_rst_w;
  assign o_illegal_w     = illegal   & i_rst_w;
  assign o_state_w       = state_q;
  assign o_instr_count_w = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs queued by stimulus,
// compared by an independent negedge monitor.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        ready = 1'b0;
  logic        iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] count;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .i_clk_w         (clk),
    .i_rst_w         (rst_n),
    .i_op_w          (op),
    .i_funct_w       (funct),
    .i_zero_w        (zero),
    .i_mem_ready_w   (ready),
    .o_iord_w        (iord),
    .o_mem_write_w   (mem_write),
    .o_ir_write_w    (ir_write),
    .o_pc_en_w       (pc_en),
    .o_reg_write_w   (reg_write),
    .o_reg_dst_w     (reg_dst),
    .o_mem_to_reg_w  (mem_to_reg),
    .o_alu_src_a_w   (alu_src_a),
    .o_alu_src_b_w   (alu_src_b),
    .o_pc_src_w      (pc_src),
    .o_alu_control_w (alu_control),
    .o_illegal_w     (illegal),
    .o_state_w       (state),
    .o_instr_count_w (count)
  );

  typedef struct {
    logic [19:0] vec;
    logic [31:0] cnt;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_idx  = 0;

  // Layout: state, {iord,mw,irw,pcen,rw,rdst,m2r,srca}, srcb, pcsrc, aluctl, illegal
  function automatic logic [19:0] v(input logic [3:0] st, input logic [7:0] en,
                                    input logic [1:0] sb, input logic [1:0] ps,
                                    input logic [2:0] ac, input logic ill);
    return {st, en, sb, ps, ac, ill};
  endfunction

  wire [19:0] act_vec = {state, iord, mem_write, ir_write, pc_en, reg_write, reg_dst,
                         mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, illegal};

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic rd, input logic [19:0] ev,
                      input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    op    = o;
    funct = f;
    zero  = z;
    ready = rd;
    e.vec = ev;
    e.cnt = ec;
    e.idx = cyc_idx;
    exp_q.push_back(e);
    cyc_idx++;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act_vec !== e.vec) begin
          n_errors++;
          $display("FAIL ctrl cycle %0d: got %b expected %b", e.idx, act_vec, e.vec);
        end
        n_checks++;
        if (count !== e.cnt) begin
          n_errors++;
          $display("FAIL count cycle %0d: got %0d expected %0d", e.idx, count, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JJ = 6'b000010, BAD = 6'b111111, BNE = 6'b000101;

  initial begin
    logic [19:0] f_rdy, f_wait, dec, dec_ill, ma, mr, mwb, mw, ex_slt, ex_ill, awb;
    logic [19:0] br_t, br_n, aex, aw2, jmp;
    logic [31:0] c;
    f_rdy   = v(4'd0,  8'b0011_0000, 2'b01, 2'b00, 3'b010, 1'b0);
    f_wait  = v(4'd0,  8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0);
    dec     = v(4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0);
    dec_ill = v(4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1);
    ma      = v(4'd2,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0);
    mr      = v(4'd3,  8'b1000_0000, 2'b00, 2'b00, 3'b010, 1'b0);
    mwb     = v(4'd4,  8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0);
    mw      = v(4'd5,  8'b1100_0000, 2'b00, 2'b00, 3'b010, 1'b0);
    ex_slt  = v(4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0);
    ex_ill  = v(4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b1);
    awb     = v(4'd7,  8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0);
    br_t    = v(4'd8,  8'b0001_0001, 2'b00, 2'b01, 3'b110, 1'b0);
    br_n    = v(4'd8,  8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0);
    aex     = v(4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0);
    aw2     = v(4'd10, 8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0);
    jmp     = v(4'd11, 8'b0001_0000, 2'b00, 2'b10, 3'b010, 1'b0);

    // Reset held with ready high: enables stay low
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, f_wait, 0);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, f_wait, 0);
    // lw: 0,1,2,3,4,0
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, f_rdy, 0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, dec,   0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, ma,    0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, mr,    0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, mwb,   0);
    // sw with three wait cycles in MEMWR
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, f_rdy, 1);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, dec,   1);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, ma,    1);
    for (int i = 0; i < 3; i++) step(1'b1, SW, 6'd0, 1'b0, 1'b0, mw, 1);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, mw,    1);
    // FETCH stall, then R-type slt
    step(1'b1, RT, 6'b101010, 1'b0, 1'b0, f_wait, 2);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, f_rdy,  2);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, dec,    2);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, ex_slt, 2);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, awb,    2);
    // beq taken, then not taken
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, f_rdy, 3);
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, dec,   3);
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, br_t,  3);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, f_rdy, 4);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, dec,   4);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, br_n,  4);
    // addi
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, f_rdy, 5);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, dec,   5);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, aex,   5);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, aw2,   5);
    // j
    step(1'b1, JJ, 6'd0, 1'b0, 1'b1, f_rdy, 6);
    step(1'b1, JJ, 6'd0, 1'b0, 1'b1, dec,   6);
    step(1'b1, JJ, 6'd0, 1'b0, 1'b1, jmp,   6);
    // Undefined opcode: one-cycle illegal, no retire
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, f_rdy,   7);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, dec_ill, 7);
    // R-type with undefined funct still completes
    step(1'b1, RT, 6'b000111, 1'b0, 1'b1, f_rdy,  7);
    step(1'b1, RT, 6'b000111, 1'b0, 1'b1, dec,    7);
    step(1'b1, RT, 6'b000111, 1'b0, 1'b1, ex_ill, 7);
    step(1'b1, RT, 6'b000111, 1'b0, 1'b1, awb,    7);
    // bne with zero=0
    step(1'b1, BNE, 6'd0, 1'b0, 1'b1, f_rdy, 8);
`ifdef MC_BNE_EN
    step(1'b1, BNE, 6'd0, 1'b0, 1'b1, dec,  8);
    step(1'b1, BNE, 6'd0, 1'b0, 1'b1, br_t, 8);
    c = 9;
`else
    step(1'b1, BNE, 6'd0, 1'b0, 1'b1, dec_ill, 8);
    c = 8;
`endif
    // lw stalled in MEMRD, then reset aborts it
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, f_rdy, c);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, dec,   c);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, ma,    c);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, mr,    c);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, mr,    c);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, f_wait, 0);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, f_wait, 0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, f_rdy,  0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, dec,    0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle MIPS datapath: one shared instruction/data memory, one ALU, and IR/PC/register-file write enables.
- Replaces the single-cycle combinational controller when the core is built as a multicycle machine.
- Sits between the instruction register's opcode/funct fields and the datapath muxes and enables.
- Adds a memory-ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- i_clk_w  in  1  clock, rising edge.
- i_rst_w  in  1  reset, asynchronous, active-low.
- i_op_w  in  6  opcode, IR[31:26].
- i_funct_w  in  6  funct, IR[5:0].
- i_zero_w  in  1  ALU zero flag.
- i_mem_ready_w  in  1  memory access completes this cycle.
- o_iord_w  out  1  0 = address memory with PC, 1 = address with ALUOut.
- o_mem_write_w  out  1  memory write enable.
- o_ir_write_w  out  1  IR load enable.
- o_pc_en_w  out  1  PC load enable.
- o_reg_write_w  out  1  register-file write enable.
- o_reg_dst_w  out  1  write-register select: 1 = rd, 0 = rt.
- o_mem_to_reg_w  out  1  write-back select: 1 = data register, 0 = ALUOut.
- o_alu_src_a_w  out  1  ALU A select: 0 = PC, 1 = register A.
- o_alu_src_b_w  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- o_pc_src_w  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- o_alu_control_w  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- o_illegal_w  out  1  one-cycle pulse on an undefined opcode.
- o_state_w  out  4  current state encoding, for debug.
- o_instr_count_w  out  CNT_W  count of retired instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Next state is registered; all control outputs are combinational from state, inputs and opcode.
- Reset (i_rst_w=0, asynchronous): state=FETCH, counter=0, o_illegal_w=0.
- While reset is held, all enables are forced 0: o_mem_write_w, o_ir_write_w, o_pc_en_w, o_reg_write_w.
- Any output not listed for a state is 0. o_alu_control_w defaults to 010.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ir_write=ready, pc_en=ready. Stay in FETCH while ready=0; go to DECODE when ready=1.
- DECODE: alu_src_a=0, alu_src_b=11 (computes branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with o_illegal_w=1 for that cycle; the counter does not increment.
- MEMADR: alu_src_a=1, alu_src_b=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold while ready=0; go to MEMWB when ready=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH; instruction retires.
- MEMWR: iord=1, mem_write=1, held high for every cycle in this state. Hold while ready=0; go to FETCH when ready=1; instruction retires on that transition.
- EXEC: alu_src_a=1, alu_src_b=00. ALU control from funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010 and o_illegal_w pulses in this cycle; the instruction still completes.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH; retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=i_zero_w. Go to FETCH; retires.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010. Go to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH; retires.
- JUMP: pc_src=10, pc_en=1. Go to FETCH; retires.
- Latency with ready held at 1, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Counter: increments by 1 on each retire edge and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it; no further write enables are issued after reset asserts.

Optional Feature:
- Macro MC_BNE_EN.
  - When defined: opcode 000101 (bne) in DECODE goes to BRANCH. In BRANCH, pc_en = ~i_zero_w for bne and i_zero_w for beq. The controller latches the opcode at DECODE into a 1-bit is_bne register for this purpose.
  - When not defined: 000101 is illegal and handled as any other undefined opcode.

Test Plan:
- Reset low, then high, ready=1, op=100011 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; count=1.
- sw with ready low for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, iord=1 throughout, count increments only when ready=1.
- R-type, funct=101010 -> EXEC drives alu_control=111; ALUWB drives reg_dst=1, reg_write=1.
- beq with zero=1 -> BRANCH drives pc_en=1, pc_src=01. Repeat with zero=0 -> pc_en=0; count increments in both cases.
- op=111111 -> DECODE goes to FETCH, o_illegal_w high exactly one cycle, count unchanged. Then assert reset during a MEMRD wait -> state=0 immediately, all enables 0, count=0.
- With MC_BNE_EN defined: op=000101, zero=0 -> pc_en=1. Without the macro: op=000101 -> o_illegal_w pulse.
